serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing diff = a - b, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion of the combinational half-adder cell, giving an area-minimal subtract datapath. Operands load on a start/busy/done handshake, and the result is held until the next operation.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared state encoding and counter sizing for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_x ^ i_y ^ i_bin;
    assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_bin_msb;
`endif

    full_subtractor u_fs (
        .i_x    (r_sa[0]),
        .i_y    (r_sb[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sa       <= '0;
            r_sb       <= '0;
            r_res      <= '0;
            r_borrow   <= 1'b0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_bin_msb  <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Result fills from the top so the first bit ends at the LSB.
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
`ifdef SERIAL_SUB_OVF_EN
                    if (r_cnt == CNT_LAST) begin
                        r_bin_msb <= r_borrow;
                    end
`endif
                    if (r_cnt == CNT_LAST) begin
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    diff       <= r_res;
                    borrow_out <= r_borrow;
                    done       <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf        <= r_bin_msb ^ r_borrow;
`endif
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       br;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];
    exp_t last;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        logic [8:0] full;
        full = {1'b0, x} - {1'b0, y};
        e.d  = full[7:0];
        e.br = (x < y);
        e.ov = (x[7] != y[7]) && (e.d[7] != x[7]);
        return e;
    endfunction

    // Output scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("borrow_out", 32'(borrow_out), 32'(e.br));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
                last = e;
            end
        end
    end

    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, output int lat, output int nb);
        lat = 0;
        nb  = 0;
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        sb_q.push_back(model(aa, bb));
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) nb++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int nb;
        int t1;
        int t2;
        logic [7:0] prev;
        n_cmp = 0;
        n_err = 0;
        last  = '0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // 1: reset values, then basic subtract with timing
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd100, 8'd58, lat, nb);
        check("latency", 32'(lat), 32'd10);
        check("busy_cycles", 32'(nb), 32'd8);

        // 2, 3: wrap-around and signed overflow cases
        run_op(8'd0, 8'd1, lat, nb);
        run_op(8'h80, 8'h01, lat, nb);
        run_op(8'h7F, 8'hFF, lat, nb);
        run_op(8'd200, 8'd201, lat, nb);

        // 4: equal operands, start during SHIFT ignored, previous result held
        prev = last.d;
        @(negedge clk);
        a = 8'd55;
        b = 8'd55;
        start = 1'b1;
        sb_q.push_back(model(8'd55, 8'd55));
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin
                a = 8'd9;
                b = 8'd3;
                start = 1'b1;
            end
            if (k == 4) begin
                start = 1'b0;
                check("hold_diff_shift", 32'(diff), 32'(prev));
            end
            if (k == 8) check("hold_diff_late", 32'(diff), 32'(prev));
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_diff", 32'(diff), 32'd0);

        // 5: start held high, back-to-back operations
        @(negedge clk);
        a = 8'd200;
        b = 8'd100;
        start = 1'b1;
        sb_q.push_back(model(8'd200, 8'd100));
        t1 = 0;
        t2 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a = 8'd10;
                b = 8'd20;
                sb_q.push_back(model(8'd10, 8'd20));
            end
            if (k == 11) start = 1'b0;
            if (done) begin
                if (t1 == 0) t1 = k;
                else begin
                    t2 = k;
                    break;
                end
            end
        end
        check("b2b_first", 32'(t1), 32'd10);
        check("b2b_spacing", 32'(t2 - t1), 32'd10);
        check("b2b_final_diff", 32'(diff), 32'd246);
        check("b2b_final_borrow", 32'(borrow_out), 32'd1);

        // 6: reset in the 4th SHIFT cycle aborts with no done pulse
        @(negedge clk);
        a = 8'd50;
        b = 8'd20;
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done_busy", 32'(busy), 32'd0);
        run_op(8'd7, 8'd2, lat, nb);
        check("post_reset_latency", 32'(lat), 32'd10);
        check("post_reset_diff", 32'(diff), 32'd5);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
